// File: rtl/test_hps_system_button_poller.sv
// Polls a 4-bit button PIO over Avalon-MM and debounces it.
// Emits per-bit press/release pulses on accepted debounced changes.
module test_hps_system_button_poller #(
  parameter int POLL_DIV   = 50000,
  parameter int DEBOUNCE_N = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic [3:0]  buttons,
  output logic [3:0]  press_pulse,
  output logic [3:0]  release_pulse,
  output logic        sample_valid
);

  localparam int CW = $clog2(POLL_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(POLL_DIV - 1);
  localparam logic [3:0] INV = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  localparam logic [3:0] DN = 4'(DEBOUNCE_N);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [3:0]    agree [4];
  logic [3:0]    sample;
  logic          unused_hi;

  assign avm_address = 2'd0;
  assign sample      = avm_readdata[3:0] ^ INV;
  assign unused_hi   = ^avm_readdata[31:4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (enable && cnt == '0) state_n = READ;
      READ:    state_n = CAPTURE;
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    avm_read     = 1'b0;
    sample_valid = 1'b0;
    unique case (1'b1)
      state == READ:    avm_read     = 1'b1;
      state == CAPTURE: sample_valid = 1'b1;
      default: ;
    endcase
  end

  // Counter freezes while enable is low and reloads on every capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= RELOAD;
    end else if (state == CAPTURE) begin
      cnt <= RELOAD;
    end else if (state == IDLE && enable && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buttons       <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int i = 0; i < 4; i++) agree[i] <= '0;
    end else begin
      press_pulse   <= '0;
      release_pulse <= '0;
      if (state == CAPTURE) begin
        for (int i = 0; i < 4; i++) begin
          if (sample[i] == buttons[i]) begin
            agree[i] <= '0;
          end else if (agree[i] + 4'd1 == DN) begin
            buttons[i]       <= ~buttons[i];
            press_pulse[i]   <= sample[i];
            release_pulse[i] <= ~sample[i];
            agree[i]         <= '0;
          end else begin
            agree[i] <= agree[i] + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_test_hps_system_button_poller.sv
// Bench for the button poller: directed scenarios plus random traffic,
// checked every cycle against a sample-history reference model.
module tb_test_hps_system_button_poller;

  localparam int P  = 4;
  localparam int D  = 3;
  localparam int AL = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = '0;
  logic [3:0]  buttons;
  logic [3:0]  press_pulse;
  logic [3:0]  release_pulse;
  logic        sample_valid;
  logic [31:0] pio = 32'hFFFF_FFFF;

  int errors = 0;
  int checks = 0;

  test_hps_system_button_poller #(
    .POLL_DIV(P), .DEBOUNCE_N(D), .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .buttons(buttons),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  // Registered PIO slave: data appears the cycle after the read strobe
  always @(posedge clk) if (avm_read) avm_readdata <= pio;

  // Reference model
  localparam int PH_IDLE = 0, PH_READ = 1, PH_CAP = 2;
  int          m_phase;
  int          m_left;
  logic [31:0] m_latched;
  logic [3:0]  m_btn, m_press, m_rel;
  logic [3:0]  hist [$];
  int          since [4];

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_left  = P;
    m_btn   = '0;
    m_press = '0;
    m_rel   = '0;
    hist.delete();
    for (int i = 0; i < 4; i++) since[i] = 0;
  endtask

  // Accept a change once the last D samples since the last change all disagree
  task automatic model_sample(input logic [3:0] raw);
    logic [3:0] s;
    int n;
    bit all;
    s = (AL != 0) ? ~raw : raw;
    hist.push_back(s);
    n = hist.size();
    for (int i = 0; i < 4; i++) begin
      if (n - since[i] >= D) begin
        all = 1'b1;
        for (int k = n - D; k < n; k++)
          if (hist[k][i] == m_btn[i]) all = 1'b0;
        if (all) begin
          m_btn[i]   = ~m_btn[i];
          m_press[i] = m_btn[i];
          m_rel[i]   = ~m_btn[i];
          since[i]   = n;
        end
      end
    end
  endtask

  task automatic model_step(input logic en, input logic [31:0] v);
    m_press = '0;
    m_rel   = '0;
    case (m_phase)
      PH_IDLE: if (en) begin
        m_left--;
        if (m_left == 0) m_phase = PH_READ;
      end
      PH_READ: begin
        m_latched = v;
        m_phase   = PH_CAP;
      end
      default: begin
        model_sample(m_latched[3:0]);
        m_left  = P;
        m_phase = PH_IDLE;
      end
    endcase
  endtask

  task automatic check_all();
    logic er, ev;
    er = (m_phase == PH_READ);
    ev = (m_phase == PH_CAP);
    checks++;
    assert (avm_address === 2'd0) else begin
      errors++; $error("FAIL addr got %h exp 0", avm_address);
    end
    checks++;
    assert (avm_read === er) else begin
      errors++; $error("FAIL avm_read t=%0t got %b exp %b", $time, avm_read, er);
    end
    checks++;
    assert (sample_valid === ev) else begin
      errors++; $error("FAIL sample_valid t=%0t got %b exp %b", $time, sample_valid, ev);
    end
    checks++;
    assert (buttons === m_btn) else begin
      errors++; $error("FAIL buttons t=%0t got %b exp %b", $time, buttons, m_btn);
    end
    checks++;
    assert (press_pulse === m_press) else begin
      errors++; $error("FAIL press t=%0t got %b exp %b", $time, press_pulse, m_press);
    end
    checks++;
    assert (release_pulse === m_rel) else begin
      errors++; $error("FAIL release t=%0t got %b exp %b", $time, release_pulse, m_rel);
    end
  endtask

  task automatic tick(input logic en, input logic [31:0] v);
    enable = en;
    pio    = v;
    model_step(en, v);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
  endtask

  task automatic run(input int n, input logic en, input logic [31:0] v);
    for (int k = 0; k < n; k++) tick(en, v);
  endtask

  task automatic seek(input int ph, input logic [31:0] v);
    for (int k = 0; k < 20 && m_phase != ph; k++) tick(1'b1, v);
    checks++;
    assert (m_phase == ph) else begin
      errors++; $error("FAIL seek phase %0d not reached", ph);
    end
  endtask

  initial begin
    logic [31:0] rv;
    logic [3:0]  seq;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    do_reset();

    // Steady bit0 pressed; upper data bits must be ignored
    run(6 * 3 + 6, 1'b1, 32'h5A5A_5A5E);

    // All four pressed then all released
    run(6 * 4, 1'b1, 32'hFFFF_FFF0);
    run(6 * 4, 1'b1, 32'h0000_000F);

    // Bit0 pressed,pressed,released,pressed,pressed,pressed
    seq = 4'b0100;
    for (int s = 0; s < 6; s++) begin
      rv = (s == 2) ? 32'hF : 32'hE;
      run(6, 1'b1, rv);
    end
    run(12, 1'b1, 32'hE);
    run(6 * 3, 1'b1, 32'hF);

    // Enable low for 10 idle cycles, then low across a read
    seek(PH_IDLE, 32'hD);
    run(10, 1'b0, 32'hD);
    seek(PH_READ, 32'hD);
    run(3, 1'b0, 32'hD);
    run(6 * 4, 1'b1, 32'hD);

    // Random traffic with sticky button levels
    rv = 32'hF;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0)
        rv = {$urandom} ^ (32'h1 << $urandom_range(0, 3));
      tick($urandom_range(0, 9) != 0, rv);
    end

    // Reset during capture with pressed data, then during read
    run(6 * 4, 1'b1, 32'hF);
    seek(PH_CAP, 32'h0);
    do_reset();
    run(6 * 4, 1'b1, 32'h0);
    seek(PH_READ, 32'h3);
    do_reset();
    run(6 * 4, 1'b1, 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
